serial_transmitter: RTL and testbench

UART-style serial transmitter. It is the transmit-side counterpart of the 16x-oversampling receive sampler in the serial transceiver.
- Runs on the same sample_clk; every line bit is held for SAMPLE_RATIO clocks.
- Frame: 1 start bit (low), 8 data bits LSB first, STOP_BITS stop bits (high).
- A one-byte holding buffer with a valid/ready handshake allows back-to-back frames with no idle gap.

---
 rtl/serial_transmitter_if.sv | 13 +
 rtl/serial_transmitter.sv | 143 ++++++++++++++
 tb/tb_serial_transmitter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_transmitter_if.sv
// Byte-producer handshake into the serial transmitter.
//   din        : byte to transmit, sampled only on an accepting edge
//   din_valid  : producer has a byte on din
//   din_ready  : transmitter holding buffer can take a byte
// The master modport is the producer side; the slave modport is the transmitter.
interface serial_transmitter_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/serial_transmitter.sv
// UART-style serial transmitter running on the oversampling sample clock.
// Each line bit is held for SAMPLE_RATIO clocks; a frame is one low start bit,
// eight data bits LSB first and STOP_BITS high stop bits. A one-byte holding
// buffer lets the next byte be accepted during the current frame so frames can
// run back to back with no idle gap.
//   sample_clk : clock, SAMPLE_RATIO x baud, all logic on the rising edge
//   rst_n      : synchronous active-low reset
//   tx         : din / din_valid / din_ready handshake (slave side)
//   dout       : registered serial line, idles high
//   busy       : frame in progress or a byte waiting in the buffer
module serial_transmitter #(
    parameter int SAMPLE_RATIO = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                 sample_clk,
    input  logic                 rst_n,
    serial_transmitter_if.slave  tx,
    output logic                 dout,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(SAMPLE_RATIO - 1);
    localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);

    state_t     state_r;
    logic [3:0] count_r;
    logic [2:0] bit_idx_r;
    logic       stop_idx_r;
    logic [7:0] shift_r;
    logic [7:0] buf_r;
    logic       buf_full_r;
    logic       dout_r;

    logic       din_ready_s;
    logic       accept_s;
    logic       bit_end_s;

    // The buffer can never accept on the edge where it hands its byte to the
    // shifter, because ready is low whenever the buffer is full.
    assign din_ready_s  = rst_n && !buf_full_r;
    assign accept_s     = tx.din_valid && din_ready_s;
    assign bit_end_s    = (count_r == LAST_COUNT);
    assign tx.din_ready = din_ready_s;
    assign dout         = dout_r;
    assign busy         = (state_r != ST_IDLE) || buf_full_r;

    // Holding buffer, bit timing and line FSM; dout is the registered line value.
    always_ff @(posedge sample_clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            count_r    <= 4'd0;
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
            shift_r    <= 8'd0;
            buf_r      <= 8'd0;
            buf_full_r <= 1'b0;
            dout_r     <= 1'b1;
        end else begin
            if (accept_s) begin
                buf_r      <= tx.din;
                buf_full_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    dout_r <= 1'b1;
                    if (buf_full_r) begin
                        shift_r    <= buf_r;
                        buf_full_r <= 1'b0;
                        count_r    <= 4'd0;
                        dout_r     <= 1'b0;
                        state_r    <= ST_START;
                    end else begin
                        count_r    <= 4'd0;
                    end
                end

                ST_START: begin
                    if (bit_end_s) begin
                        count_r   <= 4'd0;
                        bit_idx_r <= 3'd0;
                        dout_r    <= shift_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        count_r   <= count_r + 4'd1;
                    end
                end

                ST_DATA: begin
                    if (bit_end_s) begin
                        count_r <= 4'd0;
                        if (bit_idx_r == 3'd7) begin
                            stop_idx_r <= 1'b0;
                            dout_r     <= 1'b1;
                            state_r    <= ST_STOP;
                        end else begin
                            bit_idx_r  <= bit_idx_r + 3'd1;
                            dout_r     <= shift_r[bit_idx_r + 3'd1];
                        end
                    end else begin
                        count_r <= count_r + 4'd1;
                    end
                end

                ST_STOP: begin
                    if (bit_end_s) begin
                        count_r <= 4'd0;
                        if (stop_idx_r == LAST_STOP) begin
                            // Chain straight into the next start bit when a byte waits.
                            if (buf_full_r) begin
                                shift_r    <= buf_r;
                                buf_full_r <= 1'b0;
                                dout_r     <= 1'b0;
                                state_r    <= ST_START;
                            end else begin
                                dout_r     <= 1'b1;
                                state_r    <= ST_IDLE;
                            end
                        end else begin
                            stop_idx_r <= stop_idx_r + 1'b1;
                        end
                    end else begin
                        count_r <= count_r + 4'd1;
                    end
                end

                default: begin
                    count_r <= 4'd0;
                    dout_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
module tb_serial_transmitter;

    logic sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    logic rst_n;
    logic dout_a, busy_a, dout_b, busy_b, dout_c, busy_c;

    serial_transmitter_if if_a ();
    serial_transmitter_if if_b ();
    serial_transmitter_if if_c ();

    serial_transmitter #(.SAMPLE_RATIO(16), .STOP_BITS(1)) dut_a (
        .sample_clk(sample_clk), .rst_n(rst_n), .tx(if_a), .dout(dout_a), .busy(busy_a));
    serial_transmitter #(.SAMPLE_RATIO(8), .STOP_BITS(2)) dut_b (
        .sample_clk(sample_clk), .rst_n(rst_n), .tx(if_b), .dout(dout_b), .busy(busy_b));
    serial_transmitter #(.SAMPLE_RATIO(4), .STOP_BITS(1)) dut_c (
        .sample_clk(sample_clk), .rst_n(rst_n), .tx(if_c), .dout(dout_c), .busy(busy_c));

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_err = 0;
    int         rx_cnt = 0;
    logic       rx_act = 1'b0;
    logic [7:0] rx_sh  = 8'd0;

    // Expected line level at clock k (1-based) of a frame of byte b.
    function automatic logic exp_line(input logic [7:0] b, input int k, input int sr);
        int idx;
        idx = (k - 1) / sr;
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[3'(idx - 1)];
        else return 1'b1;
    endfunction

    task automatic step();
        @(posedge sample_clk);
        #1;
    endtask

    // Independent receive sampler/deserializer on dut_c (4 clocks per bit).
    always @(negedge sample_clk) begin
        if (rst_n !== 1'b1) begin
            rx_act <= 1'b0;
            rx_cnt <= 0;
        end else if (!rx_act) begin
            if (dout_c === 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % 4 == 2) begin
                if (rx_cnt / 4 == 0) begin
                    if (dout_c !== 1'b0) begin
                        rx_err <= rx_err + 1;
                        rx_act <= 1'b0;
                    end
                end else if (rx_cnt / 4 <= 8) begin
                    rx_sh[3'(rx_cnt / 4 - 1)] <= dout_c;
                end else begin
                    if (dout_c === 1'b1) rx_q.push_back(rx_sh);
                    else rx_err <= rx_err + 1;
                    rx_act <= 1'b0;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        if_a.din = 8'd0; if_a.din_valid = 1'b0;
        if_b.din = 8'd0; if_b.din_valid = 1'b0;
        if_c.din = 8'd0; if_c.din_valid = 1'b0;
        repeat (3) step();
        checks++;
        if ({dout_a, if_a.din_ready, busy_a} !== 3'b100) begin
            errors++;
            $display("FAIL reset_hold dout/ready/busy got %b want 100", {dout_a, if_a.din_ready, busy_a});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step();
            checks++;
            if ({dout_a, if_a.din_ready, busy_a} !== 3'b110) begin
                errors++;
                $display("FAIL reset_idle cycle %0d dout/ready/busy got %b want 110", k, {dout_a, if_a.din_ready, busy_a});
            end
        end
    endtask

    task automatic test_single();
        if_a.din = 8'h55; if_a.din_valid = 1'b1;
        step();
        if_a.din_valid = 1'b0;
        checks++;
        if ({dout_a, if_a.din_ready, busy_a} !== 3'b101) begin
            errors++;
            $display("FAIL single_accept dout/ready/busy got %b want 101", {dout_a, if_a.din_ready, busy_a});
        end
        for (int k = 1; k <= 160; k++) begin
            step();
            checks++;
            if (dout_a !== exp_line(8'h55, k, 16) || busy_a !== 1'b1) begin
                errors++;
                $display("FAIL single_frame clk %0d dout/busy got %b%b want %b1", k, dout_a, busy_a, exp_line(8'h55, k, 16));
            end
            if (k == 1) begin
                checks++;
                if (if_a.din_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL single_ready_after_transfer got %b want 1", if_a.din_ready);
                end
            end
        end
        step();
        checks++;
        if ({dout_a, busy_a} !== 2'b10) begin
            errors++;
            $display("FAIL single_end dout/busy got %b want 10", {dout_a, busy_a});
        end
    endtask

    task automatic test_back_to_back();
        logic want;
        if_a.din = 8'hA5; if_a.din_valid = 1'b1;
        step();
        if_a.din = 8'h3C;
        checks++;
        if (if_a.din_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full_ready got %b want 0", if_a.din_ready);
        end
        for (int k = 1; k <= 320; k++) begin
            step();
            if (k == 1) begin
                checks++;
                if (if_a.din_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_refill_ready got %b want 1", if_a.din_ready);
                end
            end
            if (k == 2) begin
                if_a.din_valid = 1'b0;
                checks++;
                if (if_a.din_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second_accept ready got %b want 0", if_a.din_ready);
                end
            end
            want = (k <= 160) ? exp_line(8'hA5, k, 16) : exp_line(8'h3C, k - 160, 16);
            checks++;
            if (dout_a !== want || busy_a !== 1'b1) begin
                errors++;
                $display("FAIL b2b_frame clk %0d dout/busy got %b%b want %b1", k, dout_a, busy_a, want);
            end
        end
        step();
        checks++;
        if ({dout_a, busy_a} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_end dout/busy got %b want 10", {dout_a, busy_a});
        end
    endtask

    task automatic test_stop_bits2();
        if_b.din = 8'h00; if_b.din_valid = 1'b1;
        step();
        if_b.din_valid = 1'b0;
        for (int k = 1; k <= 88; k++) begin
            step();
            checks++;
            if (dout_b !== exp_line(8'h00, k, 8) || busy_b !== 1'b1) begin
                errors++;
                $display("FAIL stop2_frame clk %0d dout/busy got %b%b want %b1", k, dout_b, busy_b, exp_line(8'h00, k, 8));
            end
        end
        step();
        checks++;
        if ({dout_b, busy_b} !== 2'b10) begin
            errors++;
            $display("FAIL stop2_end dout/busy got %b want 10", {dout_b, busy_b});
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got;
        logic [7:0] want;
        int guard;
        int err0;
        exp_q.delete();
        rx_q.delete();
        err0 = rx_err;
        if_c.din = 8'hC3; if_c.din_valid = 1'b1;
        step();
        exp_q.push_back(8'hC3);
        if_c.din = 8'h5A;
        step();
        step();
        exp_q.push_back(8'h5A);
        if_c.din = 8'h81;
        for (int k = 3; k <= 40; k++) begin
            step();
            if (k == 10) if_c.din = 8'hEE;
            if (k == 20) if_c.din = 8'h81;
            checks++;
            if (if_c.din_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_while_full clk %0d got %b want 0", k, if_c.din_ready);
            end
        end
        step();
        checks++;
        if (if_c.din_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after_start got %b want 1", if_c.din_ready);
        end
        step();
        exp_q.push_back(8'h81);
        if_c.din_valid = 1'b0;
        checks++;
        if (if_c.din_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_third_accept ready got %b want 0", if_c.din_ready);
        end
        guard = 0;
        while ((busy_c !== 1'b0 || rx_act) && guard < 300) begin
            step();
            guard++;
        end
        step();
        checks++;
        if (rx_q.size() != 3 || rx_err != err0) begin
            errors++;
            $display("FAIL bp_count received %0d frames err %0d want 3 frames err 0", rx_q.size(), rx_err - err0);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL bp_byte got %h want %h", got, want);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        if_a.din = 8'h0F; if_a.din_valid = 1'b1;
        step();
        if_a.din = 8'hF0;
        step();
        step();
        if_a.din_valid = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || if_a.din_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmf_buffered busy/ready got %b%b want 10", busy_a, if_a.din_ready);
        end
        for (int k = 3; k <= 40; k++) step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({dout_a, if_a.din_ready, busy_a} !== 3'b100) begin
            errors++;
            $display("FAIL rmf_reset dout/ready/busy got %b want 100", {dout_a, if_a.din_ready, busy_a});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step();
            checks++;
            if ({dout_a, busy_a} !== 2'b10) begin
                errors++;
                $display("FAIL rmf_after cycle %0d dout/busy got %b want 10", k, {dout_a, busy_a});
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] got;
        logic [7:0] want;
        logic [7:0] b;
        int guard;
        int err0;
        exp_q.delete();
        rx_q.delete();
        err0 = rx_err;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                if_c.din_valid = 1'b0;
                repeat ($urandom_range(1, 60)) step();
            end
            b = 8'($urandom_range(0, 255));
            if_c.din = b;
            if_c.din_valid = 1'b1;
            guard = 0;
            while (if_c.din_ready !== 1'b1 && guard < 200) begin
                step();
                guard++;
            end
            if (guard >= 200) begin
                checks++;
                errors++;
                $display("FAIL loop_ready_timeout byte %0d ready got %b want 1", i, if_c.din_ready);
                break;
            end
            step();
            exp_q.push_back(b);
        end
        if_c.din_valid = 1'b0;
        guard = 0;
        while ((busy_c !== 1'b0 || rx_act) && guard < 1000) begin
            step();
            guard++;
        end
        step();
        checks++;
        if (rx_q.size() != exp_q.size() || exp_q.size() != 1000 || rx_err != err0) begin
            errors++;
            $display("FAIL loop_count received %0d sent %0d err %0d want 1000 1000 0", rx_q.size(), exp_q.size(), rx_err - err0);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL loop_byte got %h want %h", got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stop_bits2();
        test_backpressure();
        test_reset_mid_frame();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not finish got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
